// File: rtl/execute_operand_stage_if.sv
// ALU operation type and the decode/memory/writeback/ALU bundle around execute_operand_stage.
// Data width comes from `BIT_COUNT, which defaults to 32 when the build does not set it.
`timescale 1ns/1ps
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package alu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } aluOperation;
endpackage

interface execute_operand_stage_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    import alu_types_pkg::*;

    logic                      decode_valid;
    logic                      decode_ready;
    aluOperation               decode_alu_op;
    logic [REG_ADDR_WIDTH-1:0] decode_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] decode_rs2_addr;
    logic [`BIT_COUNT-1:0]     decode_rs1_data;
    logic [`BIT_COUNT-1:0]     decode_rs2_data;
    logic [`BIT_COUNT-1:0]     decode_imm;
    logic                      decode_use_imm;
    logic [REG_ADDR_WIDTH-1:0] decode_rd_addr;
    logic                      decode_reg_write;
    logic                      decode_is_load;
    logic                      flush;
    logic                      pipe_stall;
    logic [REG_ADDR_WIDTH-1:0] memory_rd_addr;
    logic                      memory_reg_write;
    logic                      memory_is_load;
    logic [`BIT_COUNT-1:0]     memory_result;
    logic [REG_ADDR_WIDTH-1:0] writeback_rd_addr;
    logic                      writeback_reg_write;
    logic [`BIT_COUNT-1:0]     writeback_result;
    aluOperation               alu_op;
    logic [`BIT_COUNT-1:0]     alu_op_a;
    logic [`BIT_COUNT-1:0]     alu_op_b;
    logic                      execute_valid;
    logic [REG_ADDR_WIDTH-1:0] execute_rd_addr;
    logic                      execute_reg_write;
    logic                      execute_is_load;

    modport slave (
        input  decode_valid, decode_alu_op, decode_rs1_addr, decode_rs2_addr,
               decode_rs1_data, decode_rs2_data, decode_imm, decode_use_imm,
               decode_rd_addr, decode_reg_write, decode_is_load, flush, pipe_stall,
               memory_rd_addr, memory_reg_write, memory_is_load, memory_result,
               writeback_rd_addr, writeback_reg_write, writeback_result,
        output decode_ready, alu_op, alu_op_a, alu_op_b, execute_valid,
               execute_rd_addr, execute_reg_write, execute_is_load
    );

    modport master (
        output decode_valid, decode_alu_op, decode_rs1_addr, decode_rs2_addr,
               decode_rs1_data, decode_rs2_data, decode_imm, decode_use_imm,
               decode_rd_addr, decode_reg_write, decode_is_load, flush, pipe_stall,
               memory_rd_addr, memory_reg_write, memory_is_load, memory_result,
               writeback_rd_addr, writeback_reg_write, writeback_result,
        input  decode_ready, alu_op, alu_op_a, alu_op_b, execute_valid,
               execute_rd_addr, execute_reg_write, execute_is_load
    );
endinterface

// File: rtl/execute_operand_stage.sv
// Decode/execute pipeline register with RAW hazard handling feeding the ALU.
// FORWARDING_EN: forward from memory/writeback and stall only on load-use; otherwise stall on any RAW.
`timescale 1ns/1ps
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module execute_operand_stage
    import alu_types_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic                    clk,
    input logic                    reset_n,
    execute_operand_stage_if.slave bus
);
    localparam int W = `BIT_COUNT;

    logic                      ex_valid;
    aluOperation               ex_alu_op;
    logic [W-1:0]              ex_rs1_data;
    logic [W-1:0]              ex_rs2_data;
    logic [W-1:0]              ex_imm;
    logic                      ex_use_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
    logic                      ex_reg_write;
    logic                      ex_is_load;
`ifdef FORWARDING_EN
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr;
    logic                      mem_fwd;
    logic                      wb_fwd;
`endif
    logic                      hazard;
    logic [W-1:0]              op_a;
    logic [W-1:0]              op_b;

    // x0 is never a real producer; rs2 only counts when the immediate is not used.
    function automatic logic src_match(input logic [REG_ADDR_WIDTH-1:0] rd,
                                       input logic [REG_ADDR_WIDTH-1:0] rs1,
                                       input logic [REG_ADDR_WIDTH-1:0] rs2,
                                       input logic                      use_imm);
        return (rd != '0) && ((rd == rs1) || (!use_imm && (rd == rs2)));
    endfunction

    always_comb begin
`ifdef FORWARDING_EN
        hazard = ex_valid && ex_is_load &&
                 src_match(ex_rd_addr, bus.decode_rs1_addr, bus.decode_rs2_addr, bus.decode_use_imm);
`else
        hazard = (ex_valid && ex_reg_write &&
                  src_match(ex_rd_addr, bus.decode_rs1_addr, bus.decode_rs2_addr, bus.decode_use_imm)) ||
                 (bus.memory_reg_write &&
                  src_match(bus.memory_rd_addr, bus.decode_rs1_addr, bus.decode_rs2_addr, bus.decode_use_imm)) ||
                 (bus.writeback_reg_write &&
                  src_match(bus.writeback_rd_addr, bus.decode_rs1_addr, bus.decode_rs2_addr, bus.decode_use_imm));
`endif
    end

    assign bus.decode_ready = !bus.pipe_stall && !hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid     <= 1'b0;
            ex_alu_op    <= ALU_ADD;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_use_imm   <= 1'b0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
`ifdef FORWARDING_EN
            ex_rs1_addr  <= '0;
            ex_rs2_addr  <= '0;
`endif
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
        end else if (bus.pipe_stall) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid     <= bus.decode_valid;
            ex_alu_op    <= bus.decode_alu_op;
            ex_rs1_data  <= bus.decode_rs1_data;
            ex_rs2_data  <= bus.decode_rs2_data;
            ex_imm       <= bus.decode_imm;
            ex_use_imm   <= bus.decode_use_imm;
            ex_rd_addr   <= bus.decode_rd_addr;
            ex_reg_write <= bus.decode_reg_write;
            ex_is_load   <= bus.decode_is_load;
`ifdef FORWARDING_EN
            ex_rs1_addr  <= bus.decode_rs1_addr;
            ex_rs2_addr  <= bus.decode_rs2_addr;
`endif
        end
    end

`ifdef FORWARDING_EN
    // A load's memory-stage result is an address, not the loaded data, so it must not forward.
    assign mem_fwd = bus.memory_reg_write && (bus.memory_rd_addr != '0) && !bus.memory_is_load;
    assign wb_fwd  = bus.writeback_reg_write && (bus.writeback_rd_addr != '0);
`endif

    always_comb begin
        op_a = ex_rs1_data;
        op_b = ex_rs2_data;
`ifdef FORWARDING_EN
        if (mem_fwd && (bus.memory_rd_addr == ex_rs1_addr)) begin
            op_a = bus.memory_result;
        end else if (wb_fwd && (bus.writeback_rd_addr == ex_rs1_addr)) begin
            op_a = bus.writeback_result;
        end
        if (mem_fwd && (bus.memory_rd_addr == ex_rs2_addr)) begin
            op_b = bus.memory_result;
        end else if (wb_fwd && (bus.writeback_rd_addr == ex_rs2_addr)) begin
            op_b = bus.writeback_result;
        end
`endif
    end

    assign bus.alu_op            = ex_alu_op;
    assign bus.alu_op_a          = op_a;
    assign bus.alu_op_b          = ex_use_imm ? ex_imm : op_b;
    assign bus.execute_valid     = ex_valid;
    assign bus.execute_rd_addr   = ex_rd_addr;
    assign bus.execute_reg_write = ex_reg_write && ex_valid;
    assign bus.execute_is_load   = ex_is_load && ex_valid;
endmodule

// File: tb/tb_execute_operand_stage.sv
// Self-checking bench for execute_operand_stage: directed scenarios plus randomized
// stimulus against a behavioural model; follows the FORWARDING_EN setting of the build.
`timescale 1ns/1ps
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module tb_execute_operand_stage;
    import alu_types_pkg::*;

    localparam int RA = 5;
    localparam int W  = `BIT_COUNT;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    execute_operand_stage_if #(.REG_ADDR_WIDTH(RA)) bus();

    execute_operand_stage #(.REG_ADDR_WIDTH(RA)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        aluOperation   op;
        logic [RA-1:0] rs1;
        logic [RA-1:0] rs2;
        logic [W-1:0]  d1;
        logic [W-1:0]  d2;
        logic [W-1:0]  imm;
        logic          use_imm;
        logic [RA-1:0] rd;
        logic          rw;
        logic          ld;
    } ex_t;

    ex_t mdl;

    // True when the instruction currently in decode reads register p.
    function automatic logic reads(input logic [RA-1:0] p);
        return (p != 0) && ((p == bus.decode_rs1_addr) ||
                            (!bus.decode_use_imm && (p == bus.decode_rs2_addr)));
    endfunction

    function automatic logic model_hazard();
`ifdef FORWARDING_EN
        return mdl.valid && mdl.ld && reads(mdl.rd);
`else
        logic [RA-1:0] writers[$];
        if (mdl.valid && mdl.rw) writers.push_back(mdl.rd);
        if (bus.memory_reg_write) writers.push_back(bus.memory_rd_addr);
        if (bus.writeback_reg_write) writers.push_back(bus.writeback_rd_addr);
        foreach (writers[i]) if (reads(writers[i])) return 1'b1;
        return 1'b0;
`endif
    endfunction

`ifdef FORWARDING_EN
    // Youngest in-flight producer of register a wins; loads in memory have no data yet.
    function automatic logic [W-1:0] model_operand(input logic [RA-1:0] a, input logic [W-1:0] captured);
        if (a != 0) begin
            if (bus.memory_reg_write && !bus.memory_is_load && bus.memory_rd_addr == a)
                return bus.memory_result;
            if (bus.writeback_reg_write && bus.writeback_rd_addr == a)
                return bus.writeback_result;
        end
        return captured;
    endfunction
`endif

    function automatic ex_t model_next();
        ex_t n;
        n = mdl;
        if (bus.flush) begin
            n.valid = 1'b0;
        end else if (bus.pipe_stall) begin
            n = mdl;
        end else if (model_hazard()) begin
            n.valid = 1'b0;
        end else begin
            n.valid   = bus.decode_valid;
            n.op      = bus.decode_alu_op;
            n.rs1     = bus.decode_rs1_addr;
            n.rs2     = bus.decode_rs2_addr;
            n.d1      = bus.decode_rs1_data;
            n.d2      = bus.decode_rs2_data;
            n.imm     = bus.decode_imm;
            n.use_imm = bus.decode_use_imm;
            n.rd      = bus.decode_rd_addr;
            n.rw      = bus.decode_reg_write;
            n.ld      = bus.decode_is_load;
        end
        return n;
    endfunction

    task automatic drive_idle();
        bus.decode_valid        = 1'b0;
        bus.decode_alu_op       = ALU_ADD;
        bus.decode_rs1_addr     = '0;
        bus.decode_rs2_addr     = '0;
        bus.decode_rs1_data     = '0;
        bus.decode_rs2_data     = '0;
        bus.decode_imm          = '0;
        bus.decode_use_imm      = 1'b0;
        bus.decode_rd_addr      = '0;
        bus.decode_reg_write    = 1'b0;
        bus.decode_is_load      = 1'b0;
        bus.flush               = 1'b0;
        bus.pipe_stall          = 1'b0;
        bus.memory_rd_addr      = '0;
        bus.memory_reg_write    = 1'b0;
        bus.memory_is_load      = 1'b0;
        bus.memory_result       = '0;
        bus.writeback_rd_addr   = '0;
        bus.writeback_reg_write = 1'b0;
        bus.writeback_result    = '0;
    endtask

    task automatic drive_instr(input aluOperation op, input logic [RA-1:0] rs1, input logic [W-1:0] d1,
                               input logic [RA-1:0] rs2, input logic [W-1:0] d2,
                               input logic use_imm, input logic [W-1:0] imm,
                               input logic [RA-1:0] rd, input logic rw, input logic ld);
        bus.decode_valid     = 1'b1;
        bus.decode_alu_op    = op;
        bus.decode_rs1_addr  = rs1;
        bus.decode_rs1_data  = d1;
        bus.decode_rs2_addr  = rs2;
        bus.decode_rs2_data  = d2;
        bus.decode_use_imm   = use_imm;
        bus.decode_imm       = imm;
        bus.decode_rd_addr   = rd;
        bus.decode_reg_write = rw;
        bus.decode_is_load   = ld;
    endtask

    // Leaves the bench just after a negedge with reset released and inputs idle.
    task automatic apply_reset();
        drive_idle();
        reset_n = 1'b0;
        mdl = '0;
        mdl.op = ALU_ADD;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.execute_reg_write, bus.execute_is_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got v/rw/ld=%b%b%b want 000",
                     bus.execute_valid, bus.execute_reg_write, bus.execute_is_load);
        end
        n_tests++;
        if (bus.alu_op !== ALU_ADD) begin
            n_fail++;
            $display("FAIL reset_aluop: got %0d want %0d", bus.alu_op, ALU_ADD);
        end
        n_tests++;
        if ({bus.alu_op_a, bus.alu_op_b} !== {2*W{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_operands: got a=%h b=%h want 0/0", bus.alu_op_a, bus.alu_op_b);
        end
        n_tests++;
        if (bus.decode_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.decode_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.decode_ready, bus.execute_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got ready/valid=%b%b want 10", bus.decode_ready, bus.execute_valid);
        end
    endtask

    task automatic test_flush_stall();
        apply_reset();
        drive_instr(ALU_ADD, 5'd4, 32'd11, 5'd0, 32'd0, 1'b1, 32'd2, 5'd3, 1'b0, 1'b0);
        @(negedge clk);
        bus.pipe_stall = 1'b1;
        drive_instr(ALU_XOR, 5'd6, 32'd99, 5'd0, 32'd0, 1'b1, 32'd7, 5'd9, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b} !== {1'b1, ALU_ADD, 32'd11, 32'd2}) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b op=%0d a=%0d b=%0d want v=1 op=0 a=11 b=2",
                     bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b);
        end
        n_tests++;
        if (bus.decode_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: got %b want 0", bus.decode_ready);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.pipe_stall = 1'b0;
        drive_idle();
        #1;
        n_tests++;
        if (bus.execute_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_over_stall: got valid=%b want 0", bus.execute_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_instr(ALU_OR, 5'd2, 32'h1234, 5'd7, 32'h55, 1'b0, 32'd0, 5'd6, 1'b1, 1'b1);
        @(negedge clk);
        bus.pipe_stall = 1'b1;
        drive_idle();
        bus.pipe_stall = 1'b1;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.execute_is_load, bus.alu_op_a} !== {2'b11, 32'h1234}) begin
            n_fail++;
            $display("FAIL midreset_pre: got v=%b ld=%b a=%h want 1 1 1234",
                     bus.execute_valid, bus.execute_is_load, bus.alu_op_a);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.execute_reg_write, bus.execute_is_load, bus.alu_op,
             bus.alu_op_a, bus.alu_op_b, bus.execute_rd_addr} !== {3'b000, ALU_ADD, {2*W{1'b0}}, 5'd0}) begin
            n_fail++;
            $display("FAIL midreset_async: got v=%b rw=%b ld=%b op=%0d a=%h b=%h rd=%0d want all reset values",
                     bus.execute_valid, bus.execute_reg_write, bus.execute_is_load, bus.alu_op,
                     bus.alu_op_a, bus.alu_op_b, bus.execute_rd_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.pipe_stall = 1'b0;
        #1;
        n_tests++;
        if (bus.decode_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b want 1", bus.decode_ready);
        end
    endtask

`ifdef FORWARDING_EN
    task automatic test_back_to_back();
        apply_reset();
        drive_instr(ALU_ADD, 5'd2, 32'd5, 5'd0, 32'd0, 1'b1, 32'd3, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive_instr(ALU_SUB, 5'd1, 32'd0, 5'd0, 32'd0, 1'b1, 32'd1, 5'd2, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (bus.decode_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: got ready=%b want 1", bus.decode_ready);
        end
        @(negedge clk);
        drive_idle();
        bus.memory_rd_addr = 5'd1;
        bus.memory_reg_write = 1'b1;
        bus.memory_result = 32'd8;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b} !== {1'b1, ALU_SUB, 32'd8, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_forward: got v=%b op=%0d a=%0d b=%0d want 1 1 8 1",
                     bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive_instr(ALU_ADD, 5'd2, 32'd100, 5'd0, 32'd0, 1'b1, 32'd4, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        drive_instr(ALU_ADD, 5'd3, 32'd0, 5'd3, 32'd0, 1'b0, 32'd0, 5'd4, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (bus.decode_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_ready: got %b want 0", bus.decode_ready);
        end
        @(negedge clk);
        bus.memory_rd_addr = 5'd3;
        bus.memory_reg_write = 1'b1;
        bus.memory_is_load = 1'b1;
        bus.memory_result = 32'd104;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.decode_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL loaduse_bubble: got valid/ready=%b%b want 01", bus.execute_valid, bus.decode_ready);
        end
        @(negedge clk);
        drive_idle();
        bus.writeback_rd_addr = 5'd3;
        bus.writeback_reg_write = 1'b1;
        bus.writeback_result = 32'h77;
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.alu_op_a, bus.alu_op_b} !== {1'b1, 32'h77, 32'h77}) begin
            n_fail++;
            $display("FAIL loaduse_forward: got v=%b a=%h b=%h want 1 77 77",
                     bus.execute_valid, bus.alu_op_a, bus.alu_op_b);
        end
    endtask

    task automatic test_forward_priority();
        apply_reset();
        drive_instr(ALU_AND, 5'd5, 32'h11, 5'd0, 32'h22, 1'b0, 32'd0, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        drive_idle();
        bus.memory_rd_addr = 5'd5;
        bus.memory_reg_write = 1'b1;
        bus.memory_result = 32'd7;
        bus.writeback_rd_addr = 5'd5;
        bus.writeback_reg_write = 1'b1;
        bus.writeback_result = 32'd9;
        #1;
        n_tests++;
        if (bus.alu_op_a !== 32'd7) begin
            n_fail++;
            $display("FAIL fwd_mem_priority: got a=%0d want 7", bus.alu_op_a);
        end
        bus.memory_rd_addr = 5'd0;
        bus.memory_result = 32'hFF;
        bus.writeback_rd_addr = 5'd0;
        #1;
        n_tests++;
        if ({bus.alu_op_a, bus.alu_op_b} !== {32'h11, 32'h22}) begin
            n_fail++;
            $display("FAIL fwd_x0: got a=%h b=%h want 11 22", bus.alu_op_a, bus.alu_op_b);
        end
    endtask
`else
    task automatic test_raw_bubbles();
        apply_reset();
        drive_instr(ALU_ADD, 5'd2, 32'd5, 5'd0, 32'd0, 1'b1, 32'd3, 5'd1, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (bus.decode_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_first_ready: got %b want 1", bus.decode_ready);
        end
        @(negedge clk);
        drive_instr(ALU_SUB, 5'd1, 32'd8, 5'd0, 32'd0, 1'b1, 32'd1, 5'd2, 1'b1, 1'b0);
        // x1 visible in execute, then memory, then writeback: three stalled cycles.
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            bus.memory_rd_addr      = (c == 2) ? 5'd1 : 5'd0;
            bus.memory_reg_write    = (c == 2);
            bus.memory_result       = (c == 2) ? 32'd8 : 32'd0;
            bus.writeback_rd_addr   = (c == 3) ? 5'd1 : 5'd0;
            bus.writeback_reg_write = (c == 3);
            bus.writeback_result    = (c == 3) ? 32'd8 : 32'd0;
            #1;
            n_tests++;
            if ({bus.decode_ready, bus.execute_valid} !== {(c == 4), (c == 1)}) begin
                n_fail++;
                $display("FAIL raw_bubble_c%0d: got ready/valid=%b%b want %b%b",
                         c, bus.decode_ready, bus.execute_valid, (c == 4), (c == 1));
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if ({bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b} !== {1'b1, ALU_SUB, 32'd8, 32'd1}) begin
            n_fail++;
            $display("FAIL raw_after: got v=%b op=%0d a=%0d b=%0d want 1 1 8 1",
                     bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b);
        end
    endtask
`endif

    task automatic test_random(input int cycles);
        logic          e_ready;
        logic [W-1:0]  e_a;
        logic [W-1:0]  e_b;
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            bus.decode_valid        = ($urandom_range(0, 3) != 0);
            bus.decode_alu_op       = aluOperation'($urandom_range(0, 7));
            bus.decode_rs1_addr     = RA'($urandom_range(0, 3));
            bus.decode_rs2_addr     = RA'($urandom_range(0, 3));
            bus.decode_rs1_data     = W'($urandom);
            bus.decode_rs2_data     = W'($urandom);
            bus.decode_imm          = W'($urandom);
            bus.decode_use_imm      = ($urandom_range(0, 2) == 0);
            bus.decode_rd_addr      = RA'($urandom_range(0, 3));
            bus.decode_reg_write    = ($urandom_range(0, 1) == 1);
            bus.decode_is_load      = ($urandom_range(0, 2) == 0);
            bus.flush               = ($urandom_range(0, 9) == 0);
            bus.pipe_stall          = ($urandom_range(0, 7) == 0);
            bus.memory_rd_addr      = RA'($urandom_range(0, 3));
            bus.memory_reg_write    = ($urandom_range(0, 2) == 0);
            bus.memory_is_load      = ($urandom_range(0, 2) == 0);
            bus.memory_result       = W'($urandom);
            bus.writeback_rd_addr   = RA'($urandom_range(0, 3));
            bus.writeback_reg_write = ($urandom_range(0, 2) == 0);
            bus.writeback_result    = W'($urandom);
            #1;
            e_ready = !bus.pipe_stall && !model_hazard();
`ifdef FORWARDING_EN
            e_a = model_operand(mdl.rs1, mdl.d1);
            e_b = mdl.use_imm ? mdl.imm : model_operand(mdl.rs2, mdl.d2);
`else
            e_a = mdl.d1;
            e_b = mdl.use_imm ? mdl.imm : mdl.d2;
`endif
            n_tests++;
            if ({bus.decode_ready, bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b,
                 bus.execute_rd_addr, bus.execute_reg_write, bus.execute_is_load} !==
                {e_ready, mdl.valid, mdl.op, e_a, e_b, mdl.rd, mdl.valid && mdl.rw, mdl.valid && mdl.ld}) begin
                n_fail++;
                $display("FAIL random_c%0d: got rdy=%b v=%b op=%0d a=%h b=%h rd=%0d rw=%b ld=%b want rdy=%b v=%b op=%0d a=%h b=%h rd=%0d rw=%b ld=%b",
                         c, bus.decode_ready, bus.execute_valid, bus.alu_op, bus.alu_op_a, bus.alu_op_b,
                         bus.execute_rd_addr, bus.execute_reg_write, bus.execute_is_load,
                         e_ready, mdl.valid, mdl.op, e_a, e_b, mdl.rd, mdl.valid && mdl.rw, mdl.valid && mdl.ld);
            end
            mdl = model_next();
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_flush_stall();
        test_reset_mid();
`ifdef FORWARDING_EN
        test_back_to_back();
        test_load_use();
        test_forward_priority();
`else
        test_raw_bubbles();
`endif
        test_random(500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
